histo_frame_sequencer: RTL and testbench

HISTO_FRAME_SEQUENCER -- requirements
Module: histo_frame_sequencer

---
 rtl/histo_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_histo_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_frame_sequencer.sv
// Histogram frame sequencer: clears the bin RAM, hands it to the accumulator for one full frame, then scans it for quartile gray levels and the peak bin.
// Optional skipped-frame counter port oSkipCount is enabled by defining HISTO_SEQ_SKIP_CNT_EN.
module histo_frame_sequencer #(
  parameter int COUNT_W = 20,
  parameter int ADDR_W  = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iFvalid,
  input  logic               iGrayValid,
  input  logic [COUNT_W-1:0] iRamQ,
  output logic [ADDR_W-1:0]  oRamAddr,
  output logic               oRamWe,
  output logic [COUNT_W-1:0] oRamData,
  output logic               oAccumEn,
  output logic [ADDR_W-1:0]  oThresh25,
  output logic [ADDR_W-1:0]  oThresh,
  output logic [ADDR_W-1:0]  oThresh75,
  output logic [COUNT_W-1:0] oMaxValue,
  output logic               oDone,
  output logic               oBusy
`ifdef HISTO_SEQ_SKIP_CNT_EN
  ,output logic [7:0]        oSkipCount
`endif
);

  localparam int NBINS = 1 << ADDR_W;
  localparam int CW2   = COUNT_W + 2;
  localparam logic [ADDR_W:0]   CLEAR_LAST = (ADDR_W+1)'(NBINS - 1);
  localparam logic [ADDR_W:0]   SCAN_LAST  = (ADDR_W+1)'(NBINS);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BIN_ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_CLEAR, S_WAIT, S_ARMED, S_ACCUM, S_SCAN, S_PUBLISH
  } state_t;

  state_t r_state, w_stateNext;

  logic [ADDR_W:0]    r_cnt;
  logic [COUNT_W-1:0] r_total;
  logic [COUNT_W-1:0] r_max;
  logic [CW2-1:0]     r_cum;
  logic [2:0]         r_found;
  logic [ADDR_W-1:0]  r_th [3];
  logic [ADDR_W-1:0]  r_thresh25, r_thresh50, r_thresh75;
  logic [COUNT_W-1:0] r_maxOut;

  logic               w_consume;
  logic [ADDR_W-1:0]  w_bin;
  logic [CW2-1:0]     w_cumNext;
  logic [CW2-1:0]     w_cum4;
  logic [CW2-1:0]     w_totK [3];
  logic [2:0]         w_hit;
  logic [ADDR_W-1:0]  w_thFinal [3];
  logic [COUNT_W-1:0] w_maxNext;

  always_ff @(posedge iClk) begin
    if (!iRst_n) r_state <= S_CLEAR;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_CLEAR:   if (r_cnt == CLEAR_LAST) w_stateNext = S_WAIT;
      S_WAIT:    if (!iFvalid)            w_stateNext = S_ARMED;
      S_ARMED:   if (iFvalid)             w_stateNext = S_ACCUM;
      S_ACCUM:   if (!iFvalid)            w_stateNext = S_SCAN;
      S_SCAN:    if (r_cnt == SCAN_LAST)  w_stateNext = S_PUBLISH;
      S_PUBLISH:                          w_stateNext = S_CLEAR;
      default:                            w_stateNext = S_CLEAR;
    endcase
  end

  always_comb begin
    oRamWe   = 1'b0;
    oRamAddr = '0;
    oAccumEn = 1'b0;
    oDone    = 1'b0;
    oBusy    = 1'b0;
    case (r_state)
      S_CLEAR:   begin oRamWe = 1'b1; oRamAddr = r_cnt[ADDR_W-1:0]; oBusy = 1'b1; end
      S_ACCUM:   oAccumEn = 1'b1;
      S_SCAN:    begin oRamAddr = r_cnt[ADDR_W-1:0]; oBusy = 1'b1; end
      S_PUBLISH: begin oDone = 1'b1; oBusy = 1'b1; end
      default:   ;
    endcase
  end

  // Read data lags the address by one cycle, so scan step n consumes bin n-1.
  assign w_consume    = (r_state == S_SCAN) && (r_cnt != '0);
  assign w_bin        = r_cnt[ADDR_W-1:0] - BIN_ONE;
  assign w_cumNext    = r_cum + CW2'(iRamQ);
  assign w_cum4       = {w_cumNext[CW2-3:0], 2'b00};
  assign w_totK[0]    = CW2'(r_total);
  assign w_totK[1]    = {1'b0, r_total, 1'b0};
  assign w_totK[2]    = w_totK[0] + w_totK[1];
  assign w_maxNext    = (iRamQ > r_max) ? iRamQ : r_max;
  assign oRamData     = '0;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_hit[k] = (w_cum4 >= w_totK[k]);
      if (r_found[k])  w_thFinal[k] = r_th[k];
      else if (w_hit[k]) w_thFinal[k] = w_bin;
      else             w_thFinal[k] = '1;
    end
  end

  // Results are loaded on the final scan step so they are valid alongside oDone.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_cnt      <= '0;
      r_total    <= '0;
      r_max      <= '0;
      r_cum      <= '0;
      r_found    <= '0;
      for (int k = 0; k < 3; k++) r_th[k] <= '0;
      r_thresh25 <= '0;
      r_thresh50 <= '0;
      r_thresh75 <= '0;
      r_maxOut   <= '0;
    end else begin
      if (w_stateNext != r_state)
        r_cnt <= '0;
      else if (r_state == S_CLEAR || r_state == S_SCAN)
        r_cnt <= r_cnt + CNT_ONE;

      if (r_state == S_ARMED && iFvalid)
        r_total <= '0;
      else if (r_state == S_ACCUM && iGrayValid && r_total != '1)
        r_total <= r_total + COUNT_W'(1);

      if (r_state == S_ACCUM) begin
        r_cum   <= '0;
        r_max   <= '0;
        r_found <= '0;
      end else if (w_consume) begin
        r_cum <= w_cumNext;
        r_max <= w_maxNext;
        for (int k = 0; k < 3; k++) begin
          if (!r_found[k] && w_hit[k]) begin
            r_found[k] <= 1'b1;
            r_th[k]    <= w_bin;
          end
        end
      end

      if (r_state == S_SCAN && r_cnt == SCAN_LAST) begin
        r_thresh25 <= w_thFinal[0];
        r_thresh50 <= w_thFinal[1];
        r_thresh75 <= w_thFinal[2];
        r_maxOut   <= w_maxNext;
      end
    end
  end

  assign oThresh25 = r_thresh25;
  assign oThresh   = r_thresh50;
  assign oThresh75 = r_thresh75;
  assign oMaxValue = r_maxOut;

`ifdef HISTO_SEQ_SKIP_CNT_EN
  logic       r_fvPrev;
  logic [7:0] r_skipCount;
  logic       w_skipState;

  // A frame start seen outside ARMED can never be captured, so it is tallied.
  assign w_skipState = (r_state == S_CLEAR) || (r_state == S_SCAN) ||
                       (r_state == S_PUBLISH) || (r_state == S_WAIT);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_fvPrev    <= 1'b0;
      r_skipCount <= '0;
    end else begin
      r_fvPrev <= iFvalid;
      if (iFvalid && !r_fvPrev && w_skipState)
        r_skipCount <= r_skipCount + 8'd1;
    end
  end

  assign oSkipCount = r_skipCount;
`endif

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Directed bench for histo_frame_sequencer with a behavioural bin RAM and histogram accumulator.
// Checks oSkipCount as well when HISTO_SEQ_SKIP_CNT_EN is defined.
module tb_histo_frame_sequencer;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iFvalid;
  logic        iGrayValid;
  logic [19:0] ramQ;
  logic [7:0]  oRamAddr;
  logic        oRamWe;
  logic [19:0] oRamData;
  logic        oAccumEn;
  logic [7:0]  oThresh25, oThresh, oThresh75;
  logic [19:0] oMaxValue;
  logic        oDone;
  logic        oBusy;
`ifdef HISTO_SEQ_SKIP_CNT_EN
  logic [7:0]  oSkipCount;
`endif

  logic [19:0] ram [256];
  logic        poison;
  logic [7:0]  grayPix;
  int          doneCount = 0;
  int          accumCycles = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  histo_frame_sequencer #(.COUNT_W(20), .ADDR_W(8)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iFvalid    (iFvalid),
    .iGrayValid (iGrayValid),
    .iRamQ      (ramQ),
    .oRamAddr   (oRamAddr),
    .oRamWe     (oRamWe),
    .oRamData   (oRamData),
    .oAccumEn   (oAccumEn),
    .oThresh25  (oThresh25),
    .oThresh    (oThresh),
    .oThresh75  (oThresh75),
    .oMaxValue  (oMaxValue),
    .oDone      (oDone),
    .oBusy      (oBusy)
`ifdef HISTO_SEQ_SKIP_CNT_EN
    ,.oSkipCount (oSkipCount)
`endif
  );

  always #5 iClk = ~iClk;

  // Bin RAM with one-cycle read latency plus the accumulator that owns it in ACCUM.
  always @(posedge iClk) begin
    if (poison)
      for (int i = 0; i < 256; i++) ram[i] <= 20'(i + 7);
    else if (oRamWe)
      ram[oRamAddr] <= oRamData;
    else if (oAccumEn && iGrayValid)
      ram[grayPix] <= ram[grayPix] + 20'd1;
    ramQ <= ram[oRamAddr];
  end

  always @(posedge iClk) begin
    if (oDone === 1'b1)    doneCount   <= doneCount + 1;
    if (oAccumEn === 1'b1) accumCycles <= accumCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // pat 0: no pixels, 1: 100 each at bins 10/50/100/200, 2: bins 5,7,7,9
  task automatic applyStimulus(input int pat);
    iFvalid = 1'b1;
    @(negedge iClk);
    if (pat == 1) begin
      for (int i = 0; i < 400; i++) begin
        case (i % 4)
          0:       grayPix = 8'd10;
          1:       grayPix = 8'd50;
          2:       grayPix = 8'd100;
          default: grayPix = 8'd200;
        endcase
        iGrayValid = 1'b1;
        @(negedge iClk);
      end
    end else if (pat == 2) begin
      for (int i = 0; i < 4; i++) begin
        grayPix    = (i == 0) ? 8'd5 : (i == 3) ? 8'd9 : 8'd7;
        iGrayValid = 1'b1;
        @(negedge iClk);
      end
    end
    iGrayValid = 1'b0;
    repeat (2) @(negedge iClk);
    iFvalid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLat);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 400) begin
      @(negedge iClk);
      n++;
      if (oDone === 1'b1) seen = 1;
    end
    checkOutput({tag, "_doneLatency"}, 32'(n), 32'(expLat));
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (oBusy !== 1'b0 && n < 600) begin
      @(negedge iClk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(oBusy), 32'd0);
    repeat (2) @(negedge iClk);
  endtask

  task automatic checkResults(input string tag, input int t25, input int t50, input int t75, input int mx);
    checkOutput({tag, "_thresh25"}, 32'(oThresh25), 32'(t25));
    checkOutput({tag, "_thresh"},   32'(oThresh),   32'(t50));
    checkOutput({tag, "_thresh75"}, 32'(oThresh75), 32'(t75));
    checkOutput({tag, "_maxValue"}, 32'(oMaxValue), 32'(mx));
  endtask

  initial begin
    int n, weCycles, addrErr, nonZero, doneBefore, accumBefore;
    iRst_n = 1'b0; iFvalid = 1'b0; iGrayValid = 1'b0; grayPix = 8'd0; poison = 1'b1;
    repeat (3) @(negedge iClk);
    poison = 1'b0;

    checkOutput("reset_ramWe",   32'(oRamWe),   32'd1);
    checkOutput("reset_ramAddr", 32'(oRamAddr), 32'd0);
    checkOutput("reset_busy",    32'(oBusy),    32'd1);
    checkOutput("reset_done",    32'(oDone),    32'd0);
    checkOutput("reset_accumEn", 32'(oAccumEn), 32'd0);
    checkResults("reset", 0, 0, 0, 0);

    // Initial clear sweep after reset release
    iRst_n = 1'b1;
    n = 0; weCycles = 0; addrErr = 0;
    while (oBusy === 1'b1 && n < 400) begin
      if (oRamWe === 1'b1) begin
        if (oRamAddr !== 8'(weCycles)) addrErr++;
        weCycles++;
      end
      @(negedge iClk);
      n++;
    end
    checkOutput("clear_weCycles", 32'(weCycles), 32'd256);
    checkOutput("clear_addrErrors", 32'(addrErr), 32'd0);
    checkOutput("clear_busyLow", 32'(oBusy), 32'd0);
    nonZero = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 20'd0) nonZero++;
    checkOutput("clear_ramNonZero", 32'(nonZero), 32'd0);
    checkResults("idle", 0, 0, 0, 0);
    repeat (2) @(negedge iClk);

    // Four-bin frame
    doneBefore = doneCount;
    applyStimulus(1);
    waitDone("frameA", 258);
    waitIdle("frameA");
    checkResults("frameA", 10, 50, 100, 100);
    checkOutput("frameA_donePulses", 32'(doneCount - doneBefore), 32'd1);

    // Frame with no pixels
    doneBefore = doneCount;
    applyStimulus(0);
    waitDone("empty", 258);
    waitIdle("empty");
    checkResults("empty", 0, 0, 0, 0);
    checkOutput("empty_donePulses", 32'(doneCount - doneBefore), 32'd1);

    // Small frame followed by a frame start during SCAN
    doneBefore = doneCount;
    applyStimulus(2);
    repeat (100) @(negedge iClk);
    accumBefore = accumCycles;
    iFvalid = 1'b1; iGrayValid = 1'b1; grayPix = 8'd3;
    repeat (20) @(negedge iClk);
    iFvalid = 1'b0; iGrayValid = 1'b0;
    waitDone("frameB", 138);
    waitIdle("frameB");
    checkResults("frameB", 5, 7, 7, 2);
    checkOutput("skipScan_accumCycles", 32'(accumCycles - accumBefore), 32'd0);
    checkOutput("skipScan_donePulses", 32'(doneCount - doneBefore), 32'd1);
`ifdef HISTO_SEQ_SKIP_CNT_EN
    checkOutput("skipScan_skipCount", 32'(oSkipCount), 32'd1);
`endif
    doneBefore = doneCount;
    applyStimulus(1);
    waitDone("afterSkip", 258);
    waitIdle("afterSkip");
    checkResults("afterSkip", 10, 50, 100, 100);

    // Reset pulse in the middle of SCAN
    doneBefore = doneCount;
    applyStimulus(2);
    n = 0;
    while (!(oBusy === 1'b1 && oRamWe === 1'b0 && oRamAddr === 8'd128) && n < 400) begin
      @(negedge iClk);
      n++;
    end
    checkOutput("midScan_reachAddr128", 32'(oRamAddr), 32'd128);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    checkOutput("midScan_ramWe",   32'(oRamWe),   32'd1);
    checkOutput("midScan_ramAddr", 32'(oRamAddr), 32'd0);
    checkResults("midScanReset", 0, 0, 0, 0);
    waitIdle("midScan");
    checkOutput("midScan_donePulses", 32'(doneCount - doneBefore), 32'd0);
    checkResults("midScanHeld", 0, 0, 0, 0);
`ifdef HISTO_SEQ_SKIP_CNT_EN
    checkOutput("midScan_skipCount", 32'(oSkipCount), 32'd0);
`endif
    applyStimulus(2);
    waitDone("postReset", 258);

    // Frame already in progress when CLEAR finishes
    repeat (10) @(negedge iClk);
    doneBefore = doneCount;
    accumBefore = accumCycles;
    iFvalid = 1'b1; iGrayValid = 1'b1; grayPix = 8'd3;
    repeat (280) @(negedge iClk);
    iFvalid = 1'b0; iGrayValid = 1'b0;
    repeat (2) @(negedge iClk);
    checkOutput("lateStart_accumCycles", 32'(accumCycles - accumBefore), 32'd0);
    checkOutput("lateStart_donePulses", 32'(doneCount - doneBefore), 32'd0);
    checkResults("postReset", 5, 7, 7, 2);
`ifdef HISTO_SEQ_SKIP_CNT_EN
    checkOutput("lateStart_skipCount", 32'(oSkipCount), 32'd1);
`endif
    applyStimulus(1);
    waitDone("nextEdge", 258);
    waitIdle("nextEdge");
    checkResults("nextEdge", 10, 50, 100, 100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
